pulse_processor: RTL and testbench

Parametrised successor to the single-channel ADC pulse integrator. It samples one ADC stream and detects pulses using separate arm and release thresholds (hysteresis). For each pulse it accumulates sample count, integral and peak, then emits one packed record per pulse over a valid/ready handshake. It sits between the ADC capture logic and the readout FIFO/bus interface. Pulses that complete while the output is blocked are counted as drops.

---
 rtl/pulse_proc_pkg.sv | 46 ++++
 rtl/pulse_processor_out_reg.sv | 34 +++
 rtl/pulse_processor.sv | 134 +++++++++++++
 tb/tb_pulse_processor.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_proc_pkg.sv
// rtl/pulse_proc_pkg.sv - shared types, record layout helpers and saturating add for pulse_processor (PULSE_PROC_TIMESTAMP_EN)
package pulse_proc_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

`ifdef PULSE_PROC_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    // Record layout, LSB first: sum, count, max, then the optional timestamp.
    localparam int SUM_OFF = 0;

    function automatic int cnt_off(input int sum_w);
        return sum_w;
    endfunction

    function automatic int max_off(input int sum_w, input int cnt_w);
        return sum_w + cnt_w;
    endfunction

    function automatic int ts_off(input int sum_w, input int cnt_w, input int adc_w);
        return sum_w + cnt_w + adc_w;
    endfunction

    function automatic int rec_w(input int adc_w, input int cnt_w, input int sum_w, input int ts_w);
        return adc_w + cnt_w + sum_w + (TS_EN ? ts_w : 0);
    endfunction

    // Add two unsigned values and clamp to the all-ones value of a w-bit field (w < 64).
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b, input int w);
        logic [64:0] s;
        logic [63:0] lim;
        lim = (64'd1 << w) - 64'd1;
        s   = {1'b0, a} + {1'b0, b};
        if (s > {1'b0, lim}) begin
            return lim;
        end
        return s[63:0];
    endfunction

endpackage

// File: rtl/pulse_processor_out_reg.sv
// rtl/pulse_processor_out_reg.sv - one-entry valid/ready holding register with drop indication
module pulse_out_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         offer,
    input  logic [W-1:0] offer_data,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    output logic         drop
);

    logic load;

    // A record fits when the slot is empty or is being drained this same cycle.
    assign load = offer && (!out_valid || out_ready);
    assign drop = offer && out_valid && !out_ready;

    // Holding register: load wins over drain so back-to-back records stream at full rate.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            out_data  <= offer_data;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pulse_processor.sv
// rtl/pulse_processor.sv - hysteresis pulse detector/integrator with one-entry record output (PULSE_PROC_TIMESTAMP_EN)
module pulse_processor
    import pulse_proc_pkg::*;
#(
    parameter int ADC_W  = 8,
    parameter int CNT_W  = 24,
    parameter int SUM_W  = 32,
    parameter int DROP_W = 16,
    parameter int TS_W   = 32,
    localparam int REC_W = rec_w(ADC_W, CNT_W, SUM_W, TS_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADC_W-1:0]  adc,
    input  logic [ADC_W-1:0]  arm_th,
    input  logic [ADC_W-1:0]  release_th,
    input  logic [CNT_W-1:0]  min_len,
    input  logic              halt,
    output logic [REC_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic [DROP_W-1:0] drop_cnt
);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic [SUM_W-1:0]   sum_q, sum_n;
    logic [ADC_W-1:0]   max_q, max_n;
    logic               arm;
    logic               offer;
    logic               drop;
    logic [REC_W-1:0]   rec;

    assign busy = (state == ACTIVE);

    // Pulse FSM: arm above arm_th, continue above release_th, the ending sample is excluded.
    always_comb begin
        state_n = state;
        cnt_n   = cnt_q;
        sum_n   = sum_q;
        max_n   = max_q;
        arm     = 1'b0;
        offer   = 1'b0;
        case (state)
            IDLE: begin
                if (!halt && (adc > arm_th)) begin
                    state_n = ACTIVE;
                    cnt_n   = CNT_W'(1);
                    sum_n   = SUM_W'(adc);
                    max_n   = adc;
                    arm     = 1'b1;
                end
            end
            ACTIVE: begin
                if (halt) begin
                    state_n = IDLE;
                end else if (adc > release_th) begin
                    cnt_n = CNT_W'(sat_add(64'(cnt_q), 64'd1, CNT_W));
                    sum_n = SUM_W'(sat_add(64'(sum_q), 64'(adc), SUM_W));
                    if (adc > max_q) begin
                        max_n = adc;
                    end
                end else begin
                    state_n = IDLE;
                    offer   = (cnt_q >= min_len);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and accumulator registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt_q <= '0;
            sum_q <= '0;
            max_q <= '0;
        end else begin
            state <= state_n;
            cnt_q <= cnt_n;
            sum_q <= sum_n;
            max_q <= max_n;
        end
    end

`ifdef PULSE_PROC_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;
    logic [TS_W-1:0] ts_lat;

    // Free-running timestamp; its value at the arming edge tags the pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_cnt <= '0;
            ts_lat <= '0;
        end else begin
            ts_cnt <= ts_cnt + TS_W'(1);
            if (arm) begin
                ts_lat <= ts_cnt;
            end
        end
    end

    assign rec = {ts_lat, max_q, cnt_q, sum_q};
`else
    logic unused_arm;
    assign unused_arm = arm;
    assign rec = {max_q, cnt_q, sum_q};
`endif

    pulse_out_reg #(
        .W(REC_W)
    ) u_out_reg (
        .clk        (clk),
        .rst        (rst),
        .offer      (offer),
        .offer_data (rec),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .drop       (drop)
    );

    // Saturating count of records lost to backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != {DROP_W{1'b1}})) begin
            drop_cnt <= drop_cnt + DROP_W'(1);
        end
    end

endmodule

// File: tb/tb_pulse_processor.sv
// tb/tb_pulse_processor.sv - self-checking bench for pulse_processor (PULSE_PROC_TIMESTAMP_EN)
module tb_pulse_processor;
    import pulse_proc_pkg::*;

    localparam int REC_W   = rec_w(8, 24, 32, 32);
    localparam int S_REC_W = rec_w(8, 4, 10, 32);
    localparam longint CNT_MAX = (64'd1 << 24) - 1;
    localparam longint SUM_MAX = (64'd1 << 32) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        adc = '0;
    logic [7:0]        arm_th = 8'd10;
    logic [7:0]        release_th = 8'd5;
    logic [23:0]       min_len = 24'd1;
    logic              halt = 1'b0;
    logic              out_ready = 1'b1;
    logic [REC_W-1:0]  out_data;
    logic              out_valid;
    logic              busy;
    logic [15:0]       drop_cnt;

    logic [S_REC_W-1:0] s_data;
    logic               s_valid;
    logic               s_busy;
    logic [15:0]        s_drop;

    int passes = 0;
    int total  = 0;

    always #5 clk = ~clk;

    pulse_processor dut (
        .clk(clk), .rst(rst), .adc(adc), .arm_th(arm_th), .release_th(release_th),
        .min_len(min_len), .halt(halt), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .drop_cnt(drop_cnt)
    );

    pulse_processor #(.ADC_W(8), .CNT_W(4), .SUM_W(10), .DROP_W(16), .TS_W(32)) dut_sat (
        .clk(clk), .rst(rst), .adc(adc), .arm_th(arm_th), .release_th(release_th),
        .min_len(min_len[3:0]), .halt(halt), .out_data(s_data), .out_valid(s_valid),
        .out_ready(out_ready), .busy(s_busy), .drop_cnt(s_drop)
    );

    // Reference model: a pulse is the list of its samples; the record is derived from that list.
    bit               m_in;
    int               m_q[$];
    logic [31:0]      m_ts;
    logic [31:0]      m_arm_ts;
    bit               m_valid;
    logic [REC_W-1:0] m_rec;
    int               m_drop;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [REC_W-1:0] build_rec();
        longint s = 0;
        longint n;
        int mx = 0;
        logic [31:0] sf;
        logic [23:0] cf;
        logic [7:0]  mf;
        foreach (m_q[i]) begin
            s += m_q[i];
            if (m_q[i] > mx) mx = m_q[i];
        end
        n  = m_q.size();
        sf = 32'((s > SUM_MAX) ? SUM_MAX : s);
        cf = 24'((n > CNT_MAX) ? CNT_MAX : n);
        mf = 8'(mx);
`ifdef PULSE_PROC_TIMESTAMP_EN
        return {m_arm_ts, mf, cf, sf};
`else
        return {mf, cf, sf};
`endif
    endfunction

    task automatic model_edge();
        bit offer = 0;
        logic [REC_W-1:0] r = '0;
        if (rst) begin
            m_in = 0; m_q.delete(); m_ts = 0; m_arm_ts = 0;
            m_valid = 0; m_rec = '0; m_drop = 0;
            return;
        end
        if (m_in) begin
            if (halt) begin
                m_in = 0; m_q.delete();
            end else if (adc > release_th) begin
                m_q.push_back(int'(adc));
            end else begin
                m_in = 0;
                if (m_q.size() >= int'(min_len)) begin
                    offer = 1; r = build_rec();
                end
                m_q.delete();
            end
        end else if (!halt && adc > arm_th) begin
            m_in = 1; m_q.delete(); m_q.push_back(int'(adc)); m_arm_ts = m_ts;
        end
        if (offer) begin
            if (!m_valid || out_ready) begin
                m_rec = r; m_valid = 1;
            end else if (m_drop < 65535) begin
                m_drop++;
            end
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
        m_ts = m_ts + 1;
    endtask

    task automatic model_check();
        chk("busy", busy, m_in);
        chk("out_valid", out_valid, m_valid);
        chk("drop_cnt", drop_cnt, m_drop[15:0]);
        if (m_valid) chk("out_data", out_data, m_rec);
    endtask

    task automatic cyc(input logic [7:0] a, input logic h, input logic r);
        adc = a; halt = h; out_ready = r;
        @(posedge clk);
        model_edge();
        #1;
        model_check();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(8'd0, 1'b0, 1'b1);
        rst = 1'b0;
    endtask

    task automatic chk_rec(input string name, input int c, input int s, input int mx);
        chk({name, ".cnt"}, out_data[55:32], c);
        chk({name, ".sum"}, out_data[31:0], s);
        chk({name, ".max"}, out_data[63:56], mx);
    endtask

    typedef struct {
        logic [7:0] adc;
        logic       busy;
        logic       valid;
        int         cnt;
        int         sum;
        int         mx;
    } vec_t;

    vec_t tbl[$];

    initial begin
        // Basic pulse followed by the hysteresis scenario, out_ready held high.
        tbl.push_back('{8'd0,  1'b0, 1'b0, 0, 0, 0});
        tbl.push_back('{8'd12, 1'b1, 1'b0, 0, 0, 0});
        tbl.push_back('{8'd20, 1'b1, 1'b0, 0, 0, 0});
        tbl.push_back('{8'd7,  1'b1, 1'b0, 0, 0, 0});
        tbl.push_back('{8'd3,  1'b0, 1'b1, 3, 39, 20});
        tbl.push_back('{8'd0,  1'b0, 1'b0, 0, 0, 0});
        tbl.push_back('{8'd8,  1'b0, 1'b0, 0, 0, 0});
        tbl.push_back('{8'd9,  1'b0, 1'b0, 0, 0, 0});
        tbl.push_back('{8'd8,  1'b0, 1'b0, 0, 0, 0});
        tbl.push_back('{8'd11, 1'b1, 1'b0, 0, 0, 0});
        tbl.push_back('{8'd6,  1'b1, 1'b0, 0, 0, 0});
        tbl.push_back('{8'd6,  1'b1, 1'b0, 0, 0, 0});
        tbl.push_back('{8'd5,  1'b0, 1'b1, 3, 23, 11});
        tbl.push_back('{8'd0,  1'b0, 1'b0, 0, 0, 0});

        do_reset();
        chk("reset.busy", busy, 1'b0);
        chk("reset.valid", out_valid, 1'b0);
        chk("reset.data", out_data, '0);
        chk("reset.drop", drop_cnt, 16'd0);

        foreach (tbl[i]) begin
            cyc(tbl[i].adc, 1'b0, 1'b1);
            chk($sformatf("tbl%0d.busy", i), busy, tbl[i].busy);
            chk($sformatf("tbl%0d.valid", i), out_valid, tbl[i].valid);
            if (tbl[i].valid) chk_rec($sformatf("tbl%0d", i), tbl[i].cnt, tbl[i].sum, tbl[i].mx);
        end

        // Minimum length filter.
        do_reset();
        min_len = 24'd3;
        cyc(8'd15, 1'b0, 1'b1); cyc(8'd15, 1'b0, 1'b1); cyc(8'd0, 1'b0, 1'b1);
        chk("minlen.short_valid", out_valid, 1'b0);
        chk("minlen.short_drop", drop_cnt, 16'd0);
        cyc(8'd15, 1'b0, 1'b1); cyc(8'd15, 1'b0, 1'b1); cyc(8'd15, 1'b0, 1'b1); cyc(8'd0, 1'b0, 1'b1);
        chk("minlen.ok_valid", out_valid, 1'b1);
        chk_rec("minlen.ok", 3, 45, 15);
        min_len = 24'd1;

        // Backpressure: hold the first record, drop the next two, then load on a same-cycle accept.
        do_reset();
        cyc(8'd20, 1'b0, 1'b0); cyc(8'd0, 1'b0, 1'b0);
        cyc(8'd30, 1'b0, 1'b0); cyc(8'd0, 1'b0, 1'b0);
        cyc(8'd40, 1'b0, 1'b0); cyc(8'd0, 1'b0, 1'b0);
        chk("bp.valid", out_valid, 1'b1);
        chk_rec("bp.held", 1, 20, 20);
        chk("bp.drop", drop_cnt, 16'd2);
        cyc(8'd50, 1'b0, 1'b0); cyc(8'd0, 1'b0, 1'b1);
        chk("bp.swap_valid", out_valid, 1'b1);
        chk_rec("bp.swap", 1, 50, 50);
        chk("bp.swap_drop", drop_cnt, 16'd2);
        cyc(8'd0, 1'b0, 1'b1);
        chk("bp.drained", out_valid, 1'b0);

        // Halt mid-pulse.
        do_reset();
        repeat (4) cyc(8'd60, 1'b0, 1'b1);
        chk("halt.busy_before", busy, 1'b1);
        cyc(8'd60, 1'b1, 1'b1);
        chk("halt.busy_after", busy, 1'b0);
        chk("halt.no_rec", out_valid, 1'b0);
        cyc(8'd60, 1'b1, 1'b1);
        chk("halt.idle_held", busy, 1'b0);
        cyc(8'd50, 1'b0, 1'b1); cyc(8'd0, 1'b0, 1'b1);
        chk("halt.restart_valid", out_valid, 1'b1);
        chk_rec("halt.restart", 1, 50, 50);
        chk("halt.drop", drop_cnt, 16'd0);

        // Saturation on the narrow instance (CNT_W=4, SUM_W=10).
        do_reset();
        repeat (20) cyc(8'd255, 1'b0, 1'b1);
        cyc(8'd0, 1'b0, 1'b1);
        chk("sat.valid", s_valid, 1'b1);
        chk("sat.cnt", s_data[13:10], 4'd15);
        chk("sat.sum", s_data[9:0], 10'd1023);
        chk("sat.max", s_data[21:14], 8'd255);
        chk_rec("sat.wide", 20, 5100, 255);

        // Randomized traffic against the model.
        for (int blk = 0; blk < 5; blk++) begin
            do_reset();
            arm_th     = 8'($urandom_range(20, 200));
            release_th = 8'($urandom_range(0, 220));
            min_len    = 24'($urandom_range(1, 4));
            for (int i = 0; i < 400; i++) begin
                cyc(8'($urandom_range(0, 255)), ($urandom_range(0, 24) == 0),
                    ($urandom_range(0, 3) != 0));
            end
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
